// File: rtl/contador_comparador_n.sv
// contador_comparador_n
// N-bit modulo-MODULO up/down counter with saturating synchronous load, a
// target register, an unsigned magnitude comparator between the two, a sticky
// "target reached" flag, and per-nibble active-low 7-segment debug digits.
module contador_comparador_n #(
  parameter int N      = 8,
  parameter int MODULO = 2 ** N
) (
  input  logic               clock,
  input  logic               zera,
  input  logic               carrega,
  input  logic               registra,
  input  logic               conta,
  input  logic               sentido,
  input  logic [N-1:0]       chaves,
  output logic               menor,
  output logic               maior,
  output logic               igual,
  output logic               fim,
  output logic               atingiu,
  output logic [7*(N/4)-1:0] db_contagem,
  output logic [7*(N/4)-1:0] db_alvo
);

  localparam int          digits      = N / 4;
  localparam logic [31:0] max_count_w = 32'(MODULO - 1);
  localparam logic [N-1:0] max_count  = max_count_w[N-1:0];

  logic [N-1:0] contagem;
  logic [N-1:0] alvo;
  logic [N-1:0] carga_sat;
  logic         at_top;
  logic         at_zero;

  // Load value clamped into the legal count range 0..MODULO-1.
  always_comb begin
    carga_sat = chaves;
    if (32'(chaves) > max_count_w) carga_sat = max_count;
  end

  assign at_top  = (contagem == max_count);
  assign at_zero = (contagem == '0);

  // Counter: zera > carrega > conta > hold, wrapping at both ends of the range.
  // NOTE: every clocked register uses <= so all flops sample pre-edge values
  // together; zera is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clock) begin
    if (zera) begin
      contagem <= '0;
    end else if (carrega) begin
      contagem <= carga_sat;
    end else if (conta) begin
      if (!sentido) contagem <= at_top  ? '0        : contagem + 1'b1;
      else          contagem <= at_zero ? max_count : contagem - 1'b1;
    end
  end

  // Target register: full-width copy of chaves, independent of carrega.
  always_ff @(posedge clock) begin
    if (zera)          alvo <= '0;
    else if (registra) alvo <= chaves;
  end

  // Sticky flag: any load clears it (clear beats set); set when counting on a match.
  always_ff @(posedge clock) begin
    if (zera || carrega || registra) atingiu <= 1'b0;
    else if (conta && igual)         atingiu <= 1'b1;
  end

  // Unsigned magnitude compare of the registered count and target.
  always_comb begin
    menor = (contagem <  alvo);
    maior = (contagem >  alvo);
    igual = (contagem == alvo);
  end

  // Ripple-carry style terminal count, direction-dependent.
  assign fim = conta & (sentido ? at_zero : at_top);

  // Hex digit to active-low gfedcba segments.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] on;
    on = 7'h00;
    case (v)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      4'hF: on = 7'h71;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  // One debug digit per nibble, LSB nibble in the lowest digit.
  for (genvar k = 0; k < digits; k++) begin : g_digit
    assign db_contagem[7*k +: 7] = hex_to_seg(contagem[4*k +: 4]);
    assign db_alvo[7*k +: 7]     = hex_to_seg(alvo[4*k +: 4]);
  end

endmodule

// File: tb/tb_contador_comparador_n.sv
// Bench for contador_comparador_n: three instances (N=8 full modulus, N=8
// modulo 10, N=16) share the control inputs; an integer model predicts every
// output each cycle, and directed literal checks pin key points.
module tb_contador_comparador_n;

  logic        clock = 1'b0;
  logic        zera = 1'b0, carrega = 1'b0, registra = 1'b0, conta = 1'b0, sentido = 1'b0;
  logic [15:0] chaves = '0;

  logic [2:0]  menor_w, maior_w, igual_w, fim_w, at_w;
  logic [13:0] dbc_a, dba_a, dbc_b, dba_b;
  logic [27:0] dbc_c, dba_c;
  logic [27:0] dbc [3];
  logic [27:0] dba [3];

  always #5 clock = ~clock;

  contador_comparador_n #(.N(8)) dut_a (
    .clock(clock), .zera(zera), .carrega(carrega), .registra(registra),
    .conta(conta), .sentido(sentido), .chaves(chaves[7:0]),
    .menor(menor_w[0]), .maior(maior_w[0]), .igual(igual_w[0]), .fim(fim_w[0]),
    .atingiu(at_w[0]), .db_contagem(dbc_a), .db_alvo(dba_a));

  contador_comparador_n #(.N(8), .MODULO(10)) dut_b (
    .clock(clock), .zera(zera), .carrega(carrega), .registra(registra),
    .conta(conta), .sentido(sentido), .chaves(chaves[7:0]),
    .menor(menor_w[1]), .maior(maior_w[1]), .igual(igual_w[1]), .fim(fim_w[1]),
    .atingiu(at_w[1]), .db_contagem(dbc_b), .db_alvo(dba_b));

  contador_comparador_n #(.N(16)) dut_c (
    .clock(clock), .zera(zera), .carrega(carrega), .registra(registra),
    .conta(conta), .sentido(sentido), .chaves(chaves),
    .menor(menor_w[2]), .maior(maior_w[2]), .igual(igual_w[2]), .fim(fim_w[2]),
    .atingiu(at_w[2]), .db_contagem(dbc_c), .db_alvo(dba_c));

  assign dbc[0] = {14'b0, dbc_a};
  assign dba[0] = {14'b0, dba_a};
  assign dbc[1] = {14'b0, dbc_b};
  assign dba[1] = {14'b0, dba_b};
  assign dbc[2] = dbc_c;
  assign dba[2] = dba_c;

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model ----------------
  int unsigned mod_v [3] = '{256, 10, 65536};
  int          ndig  [3] = '{2, 2, 4};
  int unsigned m_cnt [3] = '{0, 0, 0};
  int unsigned m_alvo[3] = '{0, 0, 0};
  bit          m_at  [3] = '{0, 0, 0};

  // Lit segments (active-high gfedcba) for hex 0..F; the DUT drives the inverse.
  logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [27:0] db_exp(input int unsigned val, input int nd);
    logic [27:0] r;
    r = '0;
    for (int k = 0; k < nd; k++) r[7*k +: 7] = ~seg_on[(val >> (4*k)) & 32'hF];
    return r;
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 3; d++) begin
      int unsigned ch;
      bit          eq;
      ch = (d == 2) ? 32'(chaves) : 32'(chaves[7:0]);
      eq = (m_cnt[d] == m_alvo[d]);
      if (zera) begin
        m_cnt[d] = 0; m_alvo[d] = 0; m_at[d] = 1'b0;
      end else begin
        if (carrega)    m_cnt[d] = (ch > mod_v[d] - 1) ? mod_v[d] - 1 : ch;
        else if (conta) m_cnt[d] = sentido ? (m_cnt[d] + mod_v[d] - 1) % mod_v[d]
                                           : (m_cnt[d] + 1) % mod_v[d];
        if (registra) m_alvo[d] = ch;
        if (carrega || registra) m_at[d] = 1'b0;
        else if (conta && eq)    m_at[d] = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clock) begin
    cyc++;
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic [2:0] cmp_exp;
        logic       fim_exp;
        cmp_exp = {m_cnt[d] < m_alvo[d], m_cnt[d] > m_alvo[d], m_cnt[d] == m_alvo[d]};
        fim_exp = conta && (sentido ? (m_cnt[d] == 0) : (m_cnt[d] == mod_v[d] - 1));
        check($sformatf("dut%0d cmp cyc%0d", d, cyc), {menor_w[d], maior_w[d], igual_w[d]}, cmp_exp);
        check($sformatf("dut%0d fim cyc%0d", d, cyc), fim_w[d], fim_exp);
        check($sformatf("dut%0d atingiu cyc%0d", d, cyc), at_w[d], m_at[d]);
        check($sformatf("dut%0d db_contagem cyc%0d", d, cyc), dbc[d], db_exp(m_cnt[d], ndig[d]));
        check($sformatf("dut%0d db_alvo cyc%0d", d, cyc), dba[d], db_exp(m_alvo[d], ndig[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic z, input logic c, input logic r, input logic k,
                       input logic s, input logic [15:0] ch);
    @(negedge clock);
    #2;
    zera = z; carrega = c; registra = r; conta = k; sentido = s; chaves = ch;
  endtask

  task automatic peek();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 0, 0, 16'h0000);
    peek();
    check("reset db_contagem a", dbc_a, {7'h40, 7'h40});
    check("reset db_alvo c", dba_c, {7'h40, 7'h40, 7'h40, 7'h40});
    check("reset igual a", igual_w[0], 1'b1);
    check("reset atingiu a", at_w[0], 1'b0);
    chk_en = 1'b1;

    // Full count up: 256 edges
    for (int i = 0; i < 256; i++) drive(0, 0, 0, 1, 0, 16'h0000);
    peek();
    check("up256 a back to 0", dbc_a, {7'h40, 7'h40});
    check("up256 b at 6", dbc_b, {7'h40, 7'h02});
    check("up256 c at 0100", dbc_c, {7'h40, 7'h79, 7'h40, 7'h40});

    // Down count from 0 wraps to top
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(0, 0, 0, 1, 1, 16'h0000);
    peek();
    check("down wrap b to 9", dbc_b, {7'h40, 7'h10});
    check("down wrap a to FF", dbc_a, {7'h0E, 7'h0E});
    for (int i = 0; i < 11; i++) drive(0, 0, 0, 1, 1, 16'h0000);

    // Saturating load
    drive(0, 1, 0, 0, 0, 16'h00C3);
    peek();
    check("load C3 b saturates 9", dbc_b, {7'h40, 7'h10});
    check("load C3 a", dbc_a, {7'h46, 7'h30});

    // Compare and sticky flag
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(0, 0, 1, 0, 0, 16'h0005);
    peek();
    check("target5 cmp a", {menor_w[0], maior_w[0], igual_w[0]}, 3'b100);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0, 16'h0000);
    peek();
    check("count8 cmp a", {menor_w[0], maior_w[0], igual_w[0]}, 3'b010);
    check("count8 atingiu a", at_w[0], 1'b1);
    drive(0, 0, 1, 0, 0, 16'h0005);
    peek();
    check("registra clears atingiu a", at_w[0], 1'b0);

    // Priority: zera wins over everything
    drive(1, 1, 1, 1, 0, 16'h003A);
    peek();
    check("prio db_contagem a", dbc_a, {7'h40, 7'h40});
    check("prio db_alvo a", dba_a, {7'h40, 7'h40});
    check("prio atingiu a", at_w[0], 1'b0);

    // Simultaneous load of both registers
    drive(0, 1, 1, 0, 0, 16'h007F);
    peek();
    check("load7F igual a", igual_w[0], 1'b1);
    check("load7F atingiu a", at_w[0], 1'b0);
    drive(0, 0, 0, 1, 0, 16'h0000);
    peek();
    check("after count atingiu a", at_w[0], 1'b1);
    check("after count db a 80", dbc_a, {7'h00, 7'h40});

    // Direction reversals with no dead cycle
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, logic'(i % 3 == 0), 16'h0000);

    // 16-bit display
    drive(0, 1, 0, 0, 0, 16'hA5F0);
    peek();
    check("display A5F0 c", dbc_c, {7'h08, 7'h12, 7'h0E, 7'h40});

    drive(0, 0, 0, 0, 0, 16'h0000);
    drive(0, 0, 0, 0, 0, 16'h0000);
    @(negedge clock);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
